// File: rtl/time_bcd_display.sv
// time_bcd_display: converts a 26-bit elapsed-cycle count from the timer
// stage into eight BCD digits and eight active-low seven-segment patterns.
//
// Conversion is sequential double-dabble, one input bit per cycle.
// A request in IDLE captures i_time. The result appears 26 cycles later,
// together with a one-cycle o_done pulse. The outputs then hold until the
// next conversion completes.
//
// Ports:
//   clk      system clock, all state on the rising edge
//   rst      synchronous, active-high reset (aborts any conversion)
//   i_valid  request: capture i_time and start converting (ignored when busy)
//   i_time   26-bit unsigned binary time value
//   o_busy   high while a conversion is in progress
//   o_done   one-cycle pulse when o_bcd / o_seven have just been updated
//   o_bcd    8 BCD digits, digit k at [4k+3:4k], digit 0 least significant
//   o_seven  8 segment patterns, digit k at [7k+6:7k], {g,f,e,d,c,b,a}, active-low
//
// Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//   When defined, leading zero digits 1..7 are blanked on o_seven.
//   Digit 0 is always shown, and o_bcd is unaffected.
//   When undefined, all eight digits are always decoded.

module time_bcd_display (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [25:0] i_time,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_bcd,
    output logic [55:0] o_seven
);

    localparam int          IN_W     = 26;
    localparam int          DIGITS   = 8;
    localparam logic [4:0]  LAST_CNT = 5'(IN_W - 1);

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [IN_W-1:0]     sh_q;
    logic [4*DIGITS-1:0] acc_q;
    logic [4:0]          cnt_q;

    logic [4*DIGITS-1:0] acc_adj;
    logic [4*DIGITS-1:0] acc_nxt;
    logic [IN_W-1:0]     sh_nxt;

    logic load;
    logic step;
    logic last;

    // Single-digit decoder, active-low {g,f,e,d,c,b,a}.
    // The values 10..15 cannot be produced by the converter, so they decode to blank.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Full display encode of an 8-digit BCD word.
    function automatic logic [55:0] encode(input logic [31:0] bcd);
        logic [55:0] s;
`ifdef LEADING_ZERO_BLANK_EN
        logic        lead;
        lead = 1'b1;
        s    = '0;
        // Walk from the most significant digit down. lead stays set
        // while every digit seen so far is zero.
        for (int k = DIGITS - 1; k >= 0; k--) begin
            lead = lead && (bcd[4*k +: 4] == 4'd0);
            if (k != 0 && lead) begin
                s[7*k +: 7] = 7'b1111111;
            end else begin
                s[7*k +: 7] = seg7(bcd[4*k +: 4]);
            end
        end
`else
        s = '0;
        for (int k = 0; k < DIGITS; k++) begin
            s[7*k +: 7] = seg7(bcd[4*k +: 4]);
        end
`endif
        return s;
    endfunction

    // One double-dabble step. Each nibble is corrected on its own (no
    // carry between nibbles), then {acc, sh} shifts left by one.
    always_comb begin
        acc_adj = acc_q;
        for (int k = 0; k < DIGITS; k++) begin
            if (acc_q[4*k +: 4] >= 4'd5) begin
                acc_adj[4*k +: 4] = acc_q[4*k +: 4] + 4'd3;
            end
        end
        acc_nxt = {acc_adj[4*DIGITS-2:0], sh_q[IN_W-1]};
        sh_nxt  = {sh_q[IN_W-2:0], 1'b0};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and control.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        step    = 1'b0;
        last    = 1'b0;
        o_busy  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    load    = 1'b1;
                    state_d = CONV;
                end
            end
            CONV: begin
                o_busy = 1'b1;
                step   = 1'b1;
                // The 26th step completes on this edge, and the FSM
                // returns to IDLE on the same edge.
                if (cnt_q == LAST_CNT) begin
                    last    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Conversion datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            sh_q    <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            o_done  <= 1'b0;
            o_bcd   <= '0;
            o_seven <= encode(32'h0);
        end else begin
            o_done <= last;
            if (load) begin
                sh_q  <= i_time;
                acc_q <= '0;
                cnt_q <= '0;
            end else if (step) begin
                sh_q  <= sh_nxt;
                acc_q <= acc_nxt;
                cnt_q <= cnt_q + 5'd1;
            end
            if (last) begin
                o_bcd   <= acc_nxt;
                o_seven <= encode(acc_nxt);
            end
        end
    end

endmodule

// File: tb/tb_time_bcd_display.sv
// tb_time_bcd_display: directed tests for time_bcd_display.
// Each task drives one scenario and checks its own expected values.

module tb_time_bcd_display;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid;
    logic [25:0] i_time;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_bcd;
    logic [55:0] o_seven;

    int tests = 0;
    int fails = 0;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S6 = 7'b0000010;
    localparam logic [6:0] S7 = 7'b1111000;
    localparam logic [6:0] S8 = 7'b0000000;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] Z  = SB;
`else
    localparam logic [6:0] Z  = S0;
`endif

    time_bcd_display dut (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .i_time  (i_time),
        .o_busy  (o_busy),
        .o_done  (o_done),
        .o_bcd   (o_bcd),
        .o_seven (o_seven)
    );

    always #5 clk = ~clk;

    // Request a conversion; returns at the negedge after the accept edge.
    task automatic start(input logic [25:0] t);
        @(negedge clk);
        i_valid = 1'b1;
        i_time  = t;
        @(negedge clk);
        i_valid = 1'b0;
    endtask

    // Count edges until o_done (bounded). Optionally pulses i_valid once.
    task automatic wait_done(input int pulse_at, input logic [25:0] pv,
                             output int lat, output int busy_n);
        lat    = 0;
        busy_n = int'(o_busy);
        while (lat < 60) begin
            if (lat == pulse_at) begin
                i_valid = 1'b1;
                i_time  = pv;
            end else begin
                i_valid = 1'b0;
            end
            @(negedge clk);
            lat++;
            if (o_done) break;
            busy_n += int'(o_busy);
        end
        i_valid = 1'b0;
    endtask

    task automatic test_reset;
        logic [55:0] exp_s;
        exp_s   = {Z, Z, Z, Z, Z, Z, Z, S0};
        rst     = 1'b1;
        i_valid = 1'b0;
        i_time  = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (o_busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_busy: got %b want 0", o_busy);
        end
        tests++;
        if (o_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_done: got %b want 0", o_done);
        end
        tests++;
        if (o_bcd !== 32'h0) begin
            fails++;
            $display("FAIL reset_bcd: got %h want 0", o_bcd);
        end
        tests++;
        if (o_seven !== exp_s) begin
            fails++;
            $display("FAIL reset_seven: got %h want %h", o_seven, exp_s);
        end
    endtask

    task automatic test_zero;
        int lat, bn;
        logic [55:0] exp_s;
        exp_s = {Z, Z, Z, Z, Z, Z, Z, S0};
        start(26'd0);
        tests++;
        if (o_busy !== 1'b1) begin
            fails++;
            $display("FAIL zero_busy_after_accept: got %b want 1", o_busy);
        end
        wait_done(-1, '0, lat, bn);
        tests++;
        if (lat != 26) begin
            fails++;
            $display("FAIL zero_latency: got %0d want 26", lat);
        end
        tests++;
        if (o_bcd !== 32'h0) begin
            fails++;
            $display("FAIL zero_bcd: got %h want 0", o_bcd);
        end
        tests++;
        if (o_seven !== exp_s) begin
            fails++;
            $display("FAIL zero_seven: got %h want %h", o_seven, exp_s);
        end
        @(negedge clk);
        tests++;
        if (o_done !== 1'b0) begin
            fails++;
            $display("FAIL zero_done_one_cycle: got %b want 0", o_done);
        end
    endtask

    task automatic test_digits;
        int lat, bn;
        logic [55:0] exp_s;
        exp_s = {S1, S2, S3, S4, S5, S6, S7, S8};
        start(26'd12345678);
        wait_done(-1, '0, lat, bn);
        tests++;
        if (o_bcd !== 32'h12345678) begin
            fails++;
            $display("FAIL digits_bcd: got %h want 12345678", o_bcd);
        end
        tests++;
        if (o_seven !== exp_s) begin
            fails++;
            $display("FAIL digits_seven: got %h want %h", o_seven, exp_s);
        end
    endtask

    task automatic test_max;
        int lat, bn;
        logic [55:0] exp_s;
        exp_s = {S6, S7, S1, S0, S8, S8, S6, S3};
        start(26'h3FFFFFF);
        wait_done(-1, '0, lat, bn);
        tests++;
        if (lat != 26) begin
            fails++;
            $display("FAIL max_latency: got %0d want 26", lat);
        end
        tests++;
        if (bn != 26) begin
            fails++;
            $display("FAIL max_busy_cycles: got %0d want 26", bn);
        end
        tests++;
        if (o_bcd !== 32'h67108863) begin
            fails++;
            $display("FAIL max_bcd: got %h want 67108863", o_bcd);
        end
        tests++;
        if (o_seven !== exp_s) begin
            fails++;
            $display("FAIL max_seven: got %h want %h", o_seven, exp_s);
        end
    endtask

    task automatic test_drop;
        int lat, bn, extra;
        logic [55:0] exp_s;
        exp_s = {Z, Z, Z, Z, Z, Z, Z, S5};
        start(26'd5);
        wait_done(9, 26'd9, lat, bn);
        tests++;
        if (lat != 26) begin
            fails++;
            $display("FAIL drop_latency: got %0d want 26", lat);
        end
        tests++;
        if (o_bcd !== 32'h5) begin
            fails++;
            $display("FAIL drop_bcd: got %h want 5", o_bcd);
        end
        tests++;
        if (o_seven !== exp_s) begin
            fails++;
            $display("FAIL drop_seven: got %h want %h", o_seven, exp_s);
        end
        extra = 0;
        repeat (30) begin
            @(negedge clk);
            extra += int'(o_done) + int'(o_busy);
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL drop_no_second_conv: got %0d want 0", extra);
        end
        tests++;
        if (o_bcd !== 32'h5) begin
            fails++;
            $display("FAIL drop_bcd_held: got %h want 5", o_bcd);
        end
    endtask

    task automatic test_abort;
        int lat, bn;
        logic [55:0] exp_r;
        logic [55:0] exp_s;
        exp_r = {Z, Z, Z, Z, Z, Z, Z, S0};
        exp_s = {Z, Z, Z, Z, Z, Z, S4, S2};
        start(26'd999);
        repeat (12) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (o_busy !== 1'b0 || o_done !== 1'b0) begin
            fails++;
            $display("FAIL abort_ctrl: got busy=%b done=%b want 0 0",
                     o_busy, o_done);
        end
        tests++;
        if (o_bcd !== 32'h0) begin
            fails++;
            $display("FAIL abort_bcd: got %h want 0", o_bcd);
        end
        tests++;
        if (o_seven !== exp_r) begin
            fails++;
            $display("FAIL abort_seven: got %h want %h", o_seven, exp_r);
        end
        i_valid = 1'b1;
        i_time  = 26'd42;
        @(negedge clk);
        i_valid = 1'b0;
        wait_done(-1, '0, lat, bn);
        tests++;
        if (lat != 26) begin
            fails++;
            $display("FAIL abort_new_latency: got %0d want 26", lat);
        end
        tests++;
        if (o_bcd !== 32'h42) begin
            fails++;
            $display("FAIL abort_new_bcd: got %h want 42", o_bcd);
        end
        tests++;
        if (o_seven !== exp_s) begin
            fails++;
            $display("FAIL abort_new_seven: got %h want %h", o_seven, exp_s);
        end
    endtask

    task automatic test_back_to_back;
        int lat, gap;
        logic [55:0] exp_7;
        logic [55:0] exp_8;
        exp_7 = {Z, Z, Z, Z, Z, Z, Z, S7};
        exp_8 = {Z, Z, Z, Z, Z, Z, Z, S8};
        @(negedge clk);
        i_valid = 1'b1;
        i_time  = 26'd7;
        @(negedge clk);
        i_time = 26'd8;
        lat = 0;
        while (lat < 60) begin
            @(negedge clk);
            lat++;
            if (o_done) break;
        end
        tests++;
        if (lat != 26) begin
            fails++;
            $display("FAIL b2b_first_latency: got %0d want 26", lat);
        end
        tests++;
        if (o_bcd !== 32'h7 || o_seven !== exp_7) begin
            fails++;
            $display("FAIL b2b_first_result: got %h/%h want 7/%h",
                     o_bcd, o_seven, exp_7);
        end
        @(negedge clk);
        i_valid = 1'b0;
        gap = 1;
        while (gap < 60) begin
            @(negedge clk);
            gap++;
            if (o_done) break;
        end
        tests++;
        if (gap != 27) begin
            fails++;
            $display("FAIL b2b_done_spacing: got %0d want 27", gap);
        end
        tests++;
        if (o_bcd !== 32'h8 || o_seven !== exp_8) begin
            fails++;
            $display("FAIL b2b_second_result: got %h/%h want 8/%h",
                     o_bcd, o_seven, exp_8);
        end
    endtask

    initial begin
        rst     = 1'b1;
        i_valid = 1'b0;
        i_time  = '0;
        test_reset();
        test_zero();
        test_digits();
        test_max();
        test_drop();
        test_abort();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
